// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: bus request/response
// records, arbitration state and grant encodings, request builders.
package mem_arbiter_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    typedef enum logic {GNT_DATA, GNT_INSTR} grant_e;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        err;
    } mem_rsp_type;

    function automatic mem_req_type fetch_req(input logic [31:0] addr);
        mem_req_type r;
        r       = '0;
        r.valid = 1'b1;
        r.instr = 1'b1;
        r.addr  = addr;
        return r;
    endfunction

    function automatic mem_req_type data_req(input logic [31:0] addr,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
        mem_req_type r;
        r       = '0;
        r.valid = 1'b1;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the cpu requesters, the arbiter and the external memory.
// slave = arbiter view, master = cpu/memory environment view.
interface mem_arbiter_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_err;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_err;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;

    modport slave (
        input  imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
               memory_rdata, memory_ready,
        output imem_rdata, imem_ready, imem_err, dmem_rdata, dmem_ready, dmem_err,
               memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
    );

    modport master (
        output imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
               memory_rdata, memory_ready,
        input  imem_rdata, imem_ready, imem_err, dmem_rdata, dmem_ready, dmem_err,
               memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
    );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Bus watchdog: counts cycles while enabled, flags expiry on the TIMEOUT-th
// enabled cycle unless the bus completes in that same cycle. TIMEOUT=0 disables.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ready,
    output logic expire
);

    localparam int unsigned CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = enable ? cnt_q + 1'b1 : '0;
        expire = (TIMEOUT != 0) && enable && !ready && (cnt_q == CW'(LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single cpu memory port between instruction fetch and load/store:
// data has priority, fetch is guaranteed a grant after STARVE_LIMIT straight losses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e  state_q, state_d;
    grant_e      grant_q, grant_d;
    logic [3:0]  starve_q, starve_d;
    mem_req_type req_q, req_d;
    mem_rsp_type rsp;
    logic        fetch_win;
    logic        expire;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == BUSY),
        .ready  (bus.memory_ready),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        starve_d  = starve_q;
        req_d     = req_q;
        rsp       = '0;
        fetch_win = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.imem_valid || bus.dmem_valid) begin
                    fetch_win = bus.imem_valid &&
                                (!bus.dmem_valid || starve_q == 4'(STARVE_LIMIT));
                    state_d   = BUSY;
                    if (fetch_win) begin
                        grant_d  = GNT_INSTR;
                        starve_d = '0;
                        req_d    = fetch_req(bus.imem_addr);
                    end else begin
                        grant_d  = GNT_DATA;
                        req_d    = data_req(bus.dmem_addr, bus.dmem_wdata, bus.dmem_wstrb);
                        // Count only real losses: fetch was waiting while data won.
                        if (bus.imem_valid && starve_q != 4'hF)
                            starve_d = starve_q + 4'd1;
                    end
                end
            end
            BUSY: begin
                // A real completion beats a simultaneous watchdog expiry.
                if (bus.memory_ready) begin
                    rsp.ready   = 1'b1;
                    rsp.rdata   = bus.memory_rdata;
                    state_d     = IDLE;
                    req_d.valid = 1'b0;
                end else if (expire) begin
                    rsp.ready   = 1'b1;
                    rsp.err     = 1'b1;
                    state_d     = IDLE;
                    req_d.valid = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= GNT_DATA;
            starve_q <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            req_q    <= req_d;
        end
    end

    assign bus.memory_valid = req_q.valid;
    assign bus.memory_instr = req_q.instr;
    assign bus.memory_addr  = req_q.addr;
    assign bus.memory_wdata = req_q.wdata;
    assign bus.memory_wstrb = req_q.wstrb;

    assign bus.imem_ready = rsp.ready && (grant_q == GNT_INSTR);
    assign bus.imem_err   = rsp.err   && (grant_q == GNT_INSTR);
    assign bus.imem_rdata = (grant_q == GNT_INSTR) ? rsp.rdata : '0;
    assign bus.dmem_ready = rsp.ready && (grant_q == GNT_DATA);
    assign bus.dmem_err   = rsp.err   && (grant_q == GNT_DATA);
    assign bus.dmem_rdata = (grant_q == GNT_DATA) ? rsp.rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter; the reference model tracks
// pending requests and the fetch loss count as plain integers.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned TMO   = 8;

    logic clk;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // reference model state
    int          starve_m;
    bit          pend_i, pend_d;
    logic [31:0] ia, da, dw;
    logic [3:0]  ds;
    int          fetch_grants;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req;
        bus.imem_valid = pend_i;
        bus.imem_addr  = ia;
        bus.dmem_valid = pend_d;
        bus.dmem_addr  = da;
        bus.dmem_wdata = dw;
        bus.dmem_wstrb = ds;
    endtask

    // Called in an IDLE cycle with the pending flags set. ready_at = BUSY cycle
    // in which memory_ready is raised (1..), 0 = never (watchdog aborts at TMO).
    task automatic round(input int ready_at, input logic [31:0] rd);
        bit          win_i;
        int          last;
        logic [31:0] exp_rd;
        win_i = pend_i && (!pend_d || starve_m == int'(LIMIT));
        if (win_i) begin
            starve_m = 0;
            fetch_grants++;
        end else if (pend_i && starve_m < 15) begin
            starve_m++;
        end
        drive_req();
        tick();
        check("grant_valid", bus.memory_valid, 1);
        check("grant_instr", bus.memory_instr, win_i);
        check("grant_addr",  bus.memory_addr,  win_i ? ia : da);
        check("grant_wdata", bus.memory_wdata, win_i ? 32'h0 : dw);
        check("grant_wstrb", bus.memory_wstrb, win_i ? 32'h0 : 32'(ds));
        last   = (ready_at != 0) ? ready_at : int'(TMO);
        exp_rd = (ready_at != 0) ? rd : 32'h0;
        for (int c = 1; c <= last; c++) begin
            if (c == last && ready_at != 0) begin
                bus.memory_ready = 1'b1;
                bus.memory_rdata = rd;
            end else begin
                bus.memory_ready = 1'b0;
                bus.memory_rdata = ~rd;
            end
            #1;
            if (c < last) begin
                check("no_early_rsp", {bus.imem_ready, bus.dmem_ready, bus.imem_err, bus.dmem_err}, 0);
            end else begin
                check("imem_ready", bus.imem_ready, win_i);
                check("dmem_ready", bus.dmem_ready, !win_i);
                check("imem_err",   bus.imem_err,   win_i && ready_at == 0);
                check("dmem_err",   bus.dmem_err,   !win_i && ready_at == 0);
                check("imem_rdata", bus.imem_rdata, win_i ? exp_rd : 32'h0);
                check("dmem_rdata", bus.dmem_rdata, win_i ? 32'h0 : exp_rd);
            end
            tick();
        end
        bus.memory_ready = 1'b0;
        if (win_i) pend_i = 0;
        else       pend_d = 0;
        drive_req();
        check("bubble_valid", bus.memory_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vectors = 0; miscompares = 0; starve_m = 0; fetch_grants = 0;
        pend_i = 0; pend_d = 0; ia = '0; da = '0; dw = '0; ds = '0;
        drive_req();
        bus.memory_ready = 1'b1;
        bus.memory_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        #1;
        check("rst_mvalid", bus.memory_valid, 0);
        check("rst_maddr",  bus.memory_addr,  0);
        check("rst_rsp",    {bus.imem_ready, bus.dmem_ready, bus.imem_err, bus.dmem_err}, 0);
        check("rst_rdata",  bus.imem_rdata | bus.dmem_rdata, 0);
        #2 rst = 1'b0;
        tick();

        // memory_ready while IDLE must be ignored
        #1;
        check("idle_ready_ign", {bus.imem_ready, bus.dmem_ready}, 0);
        tick();
        check("idle_no_valid", bus.memory_valid, 0);
        bus.memory_ready = 1'b0;

        // single fetch, ready on the 2nd BUSY cycle
        pend_i = 1; ia = 32'h0000_0100;
        round(2, 32'h0000_0013);

        // simultaneous fetch and store: data first, then fetch
        pend_i = 1; ia = 32'h0000_0200;
        pend_d = 1; da = 32'h8000_0004; dw = 32'hDEAD_BEEF; ds = 4'hF;
        round(1, 32'h1111_2222);
        round(1, 32'h3333_4444);

        // starvation: data re-requests every round, fetch waits
        pend_i = 1; ia = 32'h0000_0300;
        for (int k = 0; k < 5; k++) begin
            pend_d = 1; da = 32'h8000_0100 + 32'(k * 4); dw = $urandom; ds = 4'h3;
            round(1, $urandom);
        end
        check("starve_fetch_won", 32'(pend_i), 0);

        // watchdog abort on a load
        pend_d = 1; da = 32'h8000_0040; dw = 32'h0; ds = 4'h0;
        round(0, 32'h0);

        // ready coinciding with expiry wins
        pend_d = 1; da = 32'h8000_0044; ds = 4'h0;
        round(int'(TMO), 32'hA5A5_5A5A);

        // build up fetch losses, then reset mid-transaction
        pend_i = 1; ia = 32'h0000_0400;
        for (int k = 0; k < 3; k++) begin
            pend_d = 1; da = 32'h8000_0200 + 32'(k * 4); dw = $urandom; ds = 4'hC;
            round(1, $urandom);
        end
        pend_d = 1; da = 32'h8000_0300;
        drive_req();
        tick();
        check("pre_rst_valid", bus.memory_valid, 1);
        bus.memory_ready = 1'b1;
        bus.memory_rdata = 32'hFFFF_FFFF;
        #1 rst = 1'b1;
        #1;
        check("arst_mvalid", bus.memory_valid, 0);
        check("arst_mbus",   bus.memory_addr | bus.memory_wdata, 0);
        check("arst_mstrb",  {bus.memory_instr, bus.memory_wstrb}, 0);
        check("arst_rsp",    {bus.imem_ready, bus.dmem_ready, bus.imem_err, bus.dmem_err}, 0);
        check("arst_rdata",  bus.imem_rdata | bus.dmem_rdata, 0);
        starve_m = 0;
        bus.memory_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        round(1, 32'h0BAD_F00D);

        // randomized traffic
        for (int r = 0; r < 60; r++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; ia = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            if (!pend_d && $urandom_range(0, 2) != 0) begin
                pend_d = 1; da = $urandom; dw = $urandom; ds = 4'($urandom_range(0, 15));
            end
            if (!pend_i && !pend_d) begin
                pend_d = 1; da = $urandom; dw = $urandom; ds = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 5) == 0) round(0, $urandom);
            else                            round($urandom_range(1, int'(TMO)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
